// File: rtl/m2vfb_mbwriter_if.sv
// m2vfb_mbwriter_if: Avalon-MM write port from the macroblock writer to the frame-buffer SDRAM
interface m2vfb_mbwriter_if #(parameter int MEM_WIDTH = 18) ();
  logic [MEM_WIDTH-1:0] address;
  logic                 write;
  logic [15:0]          writedata;
  logic                 read;
  logic                 waitrequest;
  modport master (output address, write, writedata, read, input waitrequest);
  modport slave  (input address, write, writedata, read, output waitrequest);
endinterface

// File: rtl/m2vfb_mbwriter.sv
// m2vfb_mbwriter: packs a 4:2:0 macroblock byte stream into 16-bit frame-buffer writes and updates the page table
module m2vfb_mbwriter #(
  parameter int MEM_WIDTH = 18,
  parameter int MBX_WIDTH = 5,
  parameter int MBY_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           softreset,
  input  logic                           mb_start,
  input  logic [MBX_WIDTH-1:0]           mb_x,
  input  logic [MBY_WIDTH-1:0]           mb_y,
  input  logic                           mb_page,
  input  logic                           mb_coded,
  input  logic                           s_valid,
  input  logic [7:0]                     s_data,
  output logic                           s_ready,
  output logic                           busy,
  output logic                           mb_done,
  m2vfb_mbwriter_if.master               fbuf,
  output logic                           ptbl_write,
  output logic [MBX_WIDTH+MBY_WIDTH-1:0] ptbl_address,
  output logic [1:0]                     ptbl_data
);
  localparam int AW = MBX_WIDTH + MBY_WIDTH + 9;
  typedef enum logic [2:0] {IDLE, LUMA, CB, CR, DRAIN, PTBL, DONE} state_t;
  state_t state, state_n;
  logic [7:0] idx, ylo;
  logic [7:0] cb_buf [64];
  logic [MBX_WIDTH-1:0] lx;
  logic [MBY_WIDTH-1:0] ly;
  logic lpg, lcoded, wr_pend, acc, word_done, last;
  logic [AW-1:0] wr_addr, nxt_addr;
  logic [15:0] wr_data;
  // word layout: {page, chroma, mb row, pixel row, mb col, word col}
  function automatic logic [AW-1:0] fb_lu(input logic pg, input logic [MBX_WIDTH-1:0] mx, input logic [2:0] x2,
                                          input logic [MBY_WIDTH-1:0] my, input logic [3:0] y);
    return {pg, 1'b0, my, y, mx, x2};
  endfunction
  function automatic logic [AW-1:0] fb_ch(input logic pg, input logic sel, input logic [MBX_WIDTH-1:0] mx,
                                          input logic [2:0] cx, input logic [MBY_WIDTH-1:0] my, input logic [3:0] cy4);
    return {pg, 1'b1, my, cy4 | {3'b000, sel}, mx, cx};
  endfunction
  assign s_ready      = (state inside {LUMA, CB, CR}) & ~(wr_pend & fbuf.waitrequest);
  assign acc          = s_valid & s_ready;
  assign word_done    = (state == LUMA) ? idx[0] : (state == CR);
  assign last         = (state == LUMA) ? (idx == 8'hFF) : (idx[5:0] == 6'h3F);
  assign nxt_addr     = (state == LUMA) ? fb_lu(lpg, lx, idx[3:1], ly, idx[7:4])
                                        : fb_ch(lpg, idx[0], lx, idx[2:0], ly, {idx[5:3], 1'b0});
  assign busy         = state != IDLE;
  assign mb_done      = state == DONE;
  assign ptbl_write   = state == PTBL;
  assign ptbl_address = {ly, lx};
  assign ptbl_data    = {lcoded, lcoded & lpg};
  assign fbuf.write     = wr_pend;
  assign fbuf.address   = MEM_WIDTH'(wr_addr);
  assign fbuf.writedata = wr_data;
  assign fbuf.read      = 1'b0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (mb_start) state_n = mb_coded ? LUMA : PTBL;
      LUMA, CB, CR: if (acc & last) state_n = state_t'(state + 3'd1);
      DRAIN:        if (~wr_pend | ~fbuf.waitrequest) state_n = PTBL;
      PTBL:         state_n = DONE;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      ylo     <= '0;
      lx      <= '0;
      ly      <= '0;
      lpg     <= 1'b0;
      lcoded  <= 1'b0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (softreset) begin
      state   <= IDLE;
      idx     <= '0;
      wr_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && mb_start) begin
        lx     <= mb_x;
        ly     <= mb_y;
        lpg    <= mb_page;
        lcoded <= mb_coded;
      end
      if (acc) idx <= (state == LUMA) ? idx + 8'd1 : {2'b00, idx[5:0] + 6'd1};
      if (acc && state == LUMA && !idx[0]) ylo <= s_data;
      if (acc && word_done) begin
        wr_pend <= 1'b1;
        wr_addr <= nxt_addr;
        wr_data <= (state == LUMA) ? {s_data, ylo} : {cb_buf[idx[5:0]], s_data};
      end else if (!fbuf.waitrequest) wr_pend <= 1'b0;
    end
  always_ff @(posedge clk)
    if (acc && state == CB) cb_buf[idx[5:0]] <= s_data;
endmodule

// File: tb/tb_m2vfb_mbwriter.sv
// tb_m2vfb_mbwriter: scoreboard bench for the macroblock frame-buffer writer
module tb_m2vfb_mbwriter;
  localparam int MW = 18, XW = 5, YW = 4;
  typedef struct packed { logic [MW-1:0] a; logic [15:0] d; } wr_t;
  logic clk = 0, reset_n = 0, softreset = 0, mb_start = 0, mb_page = 0, mb_coded = 0, s_valid = 0;
  logic [XW-1:0] mb_x = '0;
  logic [YW-1:0] mb_y = '0;
  logic [7:0] s_data = '0;
  logic s_ready, busy, mb_done, ptbl_write;
  logic [XW+YW-1:0] ptbl_address, last_pa;
  logic [1:0] ptbl_data, last_pd;
  wr_t exp_q[$], log_q[$];
  int n_cmp = 0, n_fail = 0, words = 0, ptbl_cnt = 0, done_cnt = 0, n_stalls = 0, stall_left = 0, drv_waits = 0;
  bit stall_mode = 0, hold_wait = 0, stalled_word = 0;

  m2vfb_mbwriter_if #(.MEM_WIDTH(MW)) fbuf ();
  m2vfb_mbwriter #(.MEM_WIDTH(MW), .MBX_WIDTH(XW), .MBY_WIDTH(YW)) dut (
    .clk(clk), .reset_n(reset_n), .softreset(softreset), .mb_start(mb_start), .mb_x(mb_x), .mb_y(mb_y),
    .mb_page(mb_page), .mb_coded(mb_coded), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .mb_done(mb_done), .fbuf(fbuf), .ptbl_write(ptbl_write), .ptbl_address(ptbl_address),
    .ptbl_data(ptbl_data));

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] exp_lu(input logic pg, input logic [XW-1:0] mx, input logic [2:0] x2,
                                           input logic [YW-1:0] my, input logic [3:0] y);
    return {pg, 1'b0, my, y, mx, x2};
  endfunction
  function automatic logic [MW-1:0] exp_ch(input logic pg, input logic sel, input logic [XW-1:0] mx,
                                           input logic [2:0] cx, input logic [YW-1:0] my, input logic [2:0] cy);
    return {pg, 1'b1, my, cy, sel, mx, cx};
  endfunction

  // slave model + monitor: waitrequest is decided at the negedge, transfers are seen half a cycle before the edge
  initial begin
    wr_t got, e;
    fbuf.waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_wait) fbuf.waitrequest = 1'b1;
      else if (stall_left > 0) begin fbuf.waitrequest = 1'b1; stall_left--; end
      else if (stall_mode && fbuf.write && words % 5 == 4 && !stalled_word) begin
        fbuf.waitrequest = 1'b1; stall_left = 2; stalled_word = 1; n_stalls++;
      end else fbuf.waitrequest = 1'b0;
      #1;
      if (fbuf.write && fbuf.waitrequest) begin
        n_cmp++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_stall: s_ready=%b required 0", s_ready); end
      end
      if (fbuf.write && !fbuf.waitrequest) begin
        got = {fbuf.address, fbuf.writedata};
        log_q.push_back(got);
        words++; stalled_word = 0; n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL write_unexpected: addr=%h data=%h required no write", got.a, got.d);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++; $display("FAIL write_seq: addr=%h data=%h required addr=%h data=%h", got.a, got.d, e.a, e.d);
          end
        end
      end
      if (ptbl_write) begin ptbl_cnt++; last_pa = ptbl_address; last_pd = ptbl_data; end
      if (mb_done) done_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_valid = 1; s_data = b;
    forever begin
      @(negedge clk); #2;
      if (s_ready) break;
      drv_waits++;
      if (++t > 500) begin
        n_cmp++; n_fail++; $display("FAIL byte_timeout: s_ready=0 for %0d cycles required 1", t);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic run_mb(input logic [XW-1:0] mx, input logic [YW-1:0] my, input logic pg, input logic coded,
                        input int gaps, input int poke, input bit rnd, input int luma_n);
    logic [7:0] y [256];
    logic [7:0] cb [64];
    logic [7:0] cr [64];
    for (int i = 0; i < 256; i++) y[i] = rnd ? 8'($urandom) : 8'(i);
    for (int i = 0; i < 64; i++) begin
      cb[i] = rnd ? 8'($urandom) : 8'(8'h80 + i);
      cr[i] = rnd ? 8'($urandom) : 8'(8'h40 + i);
    end
    mb_x = mx; mb_y = my; mb_page = pg; mb_coded = coded; mb_start = 1;
    @(posedge clk); #1;
    mb_start = 0; mb_x = ~mx; mb_y = ~my; mb_page = ~pg; mb_coded = ~coded;
    if (!coded) return;
    for (int i = 0; i < luma_n; i++) begin
      if (i % 2 == 1) exp_q.push_back({exp_lu(pg, mx, 3'(i >> 1), my, 4'(i >> 4)), y[i], y[i-1]});
      if (i == poke) mb_start = 1;
      send_byte(y[i]);
      mb_start = 0;
      repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
    end
    if (luma_n < 256) return;
    for (int i = 0; i < 64; i++) begin
      send_byte(cb[i]);
      repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({exp_ch(pg, 1'(i), mx, 3'(i), my, 3'(i >> 3)), cb[i], cr[i]});
      send_byte(cr[i]);
      repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int t = 0;
    while (done_cnt == d0 && t < 2000) begin @(posedge clk); #1; t++; end
    ok = done_cnt != d0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp += 6;
    if (s_ready !== 0)    begin n_fail++; $display("FAIL reset_s_ready: %b required 0", s_ready); end
    if (busy !== 0)       begin n_fail++; $display("FAIL reset_busy: %b required 0", busy); end
    if (mb_done !== 0)    begin n_fail++; $display("FAIL reset_mb_done: %b required 0", mb_done); end
    if (fbuf.write !== 0) begin n_fail++; $display("FAIL reset_fbuf_write: %b required 0", fbuf.write); end
    if (ptbl_write !== 0) begin n_fail++; $display("FAIL reset_ptbl_write: %b required 0", ptbl_write); end
    if (fbuf.read !== 0)  begin n_fail++; $display("FAIL reset_fbuf_read: %b required 0", fbuf.read); end
    @(negedge clk); reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 0 || s_ready !== 0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b s_ready=%b required 0 0", busy, s_ready); end
  endtask

  task automatic test_coded();
    int d0 = done_cnt, p0 = ptbl_cnt, w0 = drv_waits;
    bit ok;
    log_q.delete();
    run_mb(5'd2, 4'd1, 1'b1, 1'b1, 0, -1, 0, 256);
    wait_done(d0, ok);
    n_cmp += 9;
    if (!ok) begin n_fail++; $display("FAIL coded_done: no mb_done required one"); end
    if (log_q.size() != 192) begin n_fail++; $display("FAIL coded_count: %0d words required 192", log_q.size()); end
    if (log_q.size() > 128) begin
      if (log_q[0] !== {18'h21010, 16'h0100}) begin n_fail++; $display("FAIL coded_first: %h required %h", log_q[0], {18'h21010, 16'h0100}); end
      if (log_q[128] !== {18'h31010, 16'h8040}) begin n_fail++; $display("FAIL coded_chroma: %h required %h", log_q[128], {18'h31010, 16'h8040}); end
    end else begin n_fail += 2; $display("FAIL coded_words: %0d words required 192", log_q.size()); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL coded_left: %0d words pending required 0", exp_q.size()); end
    if (ptbl_cnt - p0 != 1) begin n_fail++; $display("FAIL coded_ptbl_cnt: %0d required 1", ptbl_cnt - p0); end
    if (last_pa !== {4'd1, 5'd2} || last_pd !== 2'b11) begin n_fail++; $display("FAIL coded_ptbl: addr=%h data=%b required addr=%h data=11", last_pa, last_pd, {4'd1, 5'd2}); end
    if (drv_waits != w0) begin n_fail++; $display("FAIL coded_rate: %0d stall cycles required 0", drv_waits - w0); end
    if (busy !== 0) begin n_fail++; $display("FAIL coded_busy: %b required 0", busy); end
  endtask

  task automatic test_stall();
    int d0 = done_cnt, p0 = ptbl_cnt, s0 = n_stalls, w0 = drv_waits;
    bit ok;
    log_q.delete();
    words = 0; stall_mode = 1;
    run_mb(5'd2, 4'd1, 1'b1, 1'b1, 0, -1, 0, 256);
    wait_done(d0, ok);
    stall_mode = 0;
    n_cmp += 6;
    if (!ok) begin n_fail++; $display("FAIL stall_done: no mb_done required one"); end
    if (log_q.size() != 192) begin n_fail++; $display("FAIL stall_count: %0d words required 192", log_q.size()); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_left: %0d pending required 0", exp_q.size()); end
    if (n_stalls - s0 != 38) begin n_fail++; $display("FAIL stall_events: %0d required 38", n_stalls - s0); end
    if (drv_waits == w0) begin n_fail++; $display("FAIL stall_backpressure: 0 wait cycles required >0"); end
    if (ptbl_cnt - p0 != 1 || last_pd !== 2'b11) begin n_fail++; $display("FAIL stall_ptbl: cnt=%0d data=%b required 1 11", ptbl_cnt - p0, last_pd); end
  endtask

  task automatic test_skip();
    int c0 = words, d0 = done_cnt;
    mb_x = 5'd3; mb_y = 4'd2; mb_page = 1; mb_coded = 0; mb_start = 1;
    s_valid = 1; s_data = 8'hAA;
    @(posedge clk); #1;
    mb_start = 0;
    @(negedge clk); #2;
    n_cmp += 3;
    if (ptbl_write !== 1) begin n_fail++; $display("FAIL skip_ptbl_write: %b required 1", ptbl_write); end
    if (ptbl_data !== 2'b00 || ptbl_address !== {4'd2, 5'd3}) begin n_fail++; $display("FAIL skip_ptbl: addr=%h data=%b required addr=%h data=00", ptbl_address, ptbl_data, {4'd2, 5'd3}); end
    if (s_ready !== 0 || busy !== 1) begin n_fail++; $display("FAIL skip_flags: s_ready=%b busy=%b required 0 1", s_ready, busy); end
    @(negedge clk); #2;
    n_cmp++;
    if (mb_done !== 1 || ptbl_write !== 0 || s_ready !== 0) begin n_fail++; $display("FAIL skip_done: mb_done=%b ptbl_write=%b s_ready=%b required 1 0 0", mb_done, ptbl_write, s_ready); end
    @(negedge clk); #2;
    n_cmp += 2;
    if (mb_done !== 0 || busy !== 0) begin n_fail++; $display("FAIL skip_idle: mb_done=%b busy=%b required 0 0", mb_done, busy); end
    if (words != c0 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL skip_bus: writes=%0d dones=%0d required 0 1", words - c0, done_cnt - d0); end
    s_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    int d0 = done_cnt, p0 = ptbl_cnt;
    bit ok;
    log_q.delete();
    run_mb(5'd4, 4'd3, 1'b0, 1'b1, 0, 50, 0, 256);
    wait_done(d0, ok);
    repeat (5) @(posedge clk);
    #1;
    n_cmp += 4;
    if (!ok || done_cnt - d0 != 1) begin n_fail++; $display("FAIL restart_done: %0d dones required 1", done_cnt - d0); end
    if (log_q.size() != 192 || exp_q.size() != 0) begin n_fail++; $display("FAIL restart_words: %0d words %0d pending required 192 0", log_q.size(), exp_q.size()); end
    if (ptbl_cnt - p0 != 1) begin n_fail++; $display("FAIL restart_ptbl_cnt: %0d required 1", ptbl_cnt - p0); end
    if (last_pa !== {4'd3, 5'd4} || last_pd !== 2'b10) begin n_fail++; $display("FAIL restart_ptbl: addr=%h data=%b required addr=%h data=10", last_pa, last_pd, {4'd3, 5'd4}); end
  endtask

  task automatic test_softreset();
    int d0 = done_cnt, p0 = ptbl_cnt;
    bit ok;
    run_mb(5'd1, 4'd1, 1'b0, 1'b1, 0, -1, 0, 100);
    hold_wait = 1;
    @(negedge clk); #2;
    n_cmp += 2;
    if (fbuf.write !== 1) begin n_fail++; $display("FAIL sr_stalled: fbuf_write=%b required 1", fbuf.write); end
    if (exp_q.size() != 1) begin n_fail++; $display("FAIL sr_pending: %0d queued required 1", exp_q.size()); end
    @(posedge clk); #1; softreset = 1;
    @(posedge clk); #1; softreset = 0;
    @(negedge clk); #2;
    n_cmp++;
    if (fbuf.write !== 0 || busy !== 0) begin n_fail++; $display("FAIL sr_abort: fbuf_write=%b busy=%b required 0 0", fbuf.write, busy); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (ptbl_cnt != p0 || done_cnt != d0) begin n_fail++; $display("FAIL sr_no_finish: ptbl=%0d done=%0d required 0 0", ptbl_cnt - p0, done_cnt - d0); end
    exp_q.delete(); log_q.delete(); hold_wait = 0;
    @(posedge clk); #1;
    run_mb(5'd6, 4'd5, 1'b1, 1'b1, 0, -1, 1, 256);
    wait_done(d0, ok);
    n_cmp += 2;
    if (!ok || log_q.size() != 192 || exp_q.size() != 0) begin n_fail++; $display("FAIL sr_next_mb: done=%b words=%0d pending=%0d required 1 192 0", ok, log_q.size(), exp_q.size()); end
    if (last_pa !== {4'd5, 5'd6} || last_pd !== 2'b11) begin n_fail++; $display("FAIL sr_next_ptbl: addr=%h data=%b required addr=%h data=11", last_pa, last_pd, {4'd5, 5'd6}); end
  endtask

  task automatic test_maxidx();
    int d0 = done_cnt;
    bit ok;
    log_q.delete();
    run_mb('1, '1, 1'b1, 1'b1, 2, -1, 1, 256);
    wait_done(d0, ok);
    repeat (10) @(posedge clk);
    #1;
    n_cmp += 5;
    if (!ok || done_cnt - d0 != 1) begin n_fail++; $display("FAIL max_done: %0d dones required 1", done_cnt - d0); end
    if (log_q.size() != 192 || exp_q.size() != 0) begin n_fail++; $display("FAIL max_words: %0d words %0d pending required 192 0", log_q.size(), exp_q.size()); end
    if (log_q.size() == 192) begin
      if (log_q[127].a !== 18'h2FFFF) begin n_fail++; $display("FAIL max_luma_addr: %h required 2ffff", log_q[127].a); end
      if (log_q[191].a !== 18'h3FFFF) begin n_fail++; $display("FAIL max_chroma_addr: %h required 3ffff", log_q[191].a); end
    end else begin n_fail += 2; $display("FAIL max_addr: %0d words required 192", log_q.size()); end
    if (last_pa !== 9'h1FF || last_pd !== 2'b11) begin n_fail++; $display("FAIL max_ptbl: addr=%h data=%b required 1ff 11", last_pa, last_pd); end
  endtask

  initial begin
    test_reset();
    test_coded();
    test_stall();
    test_skip();
    test_restart();
    test_softreset();
    test_maxidx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
